// File: rtl/insn_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch unit: FSM states, trap codes,
// opcode constants and immediate classification.
package insn_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_OPC   = 3'd3,
      ST_LEB   = 3'd4,
      ST_DONE  = 3'd5,
      ST_TRAP  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I32  = 2'd1,
      IMM_I64  = 2'd2,
      IMM_U32  = 2'd3
   } imm_kind_e;

   localparam logic [3:0] TRAP_NONE         = 4'd0;
   localparam logic [3:0] TRAP_MEM          = 4'd1;
   localparam logic [3:0] TRAP_LEB_OVERLONG = 4'd2;

   localparam logic [7:0] OP_BR         = 8'h0C;
   localparam logic [7:0] OP_BR_IF      = 8'h0D;
   localparam logic [7:0] OP_CALL       = 8'h10;
   localparam logic [7:0] OP_LOCAL_GET  = 8'h20;
   localparam logic [7:0] OP_LOCAL_SET  = 8'h21;
   localparam logic [7:0] OP_LOCAL_TEE  = 8'h22;
   localparam logic [7:0] OP_GLOBAL_GET = 8'h23;
   localparam logic [7:0] OP_GLOBAL_SET = 8'h24;
   localparam logic [7:0] OP_I32_CONST  = 8'h41;
   localparam logic [7:0] OP_I64_CONST  = 8'h42;

   // Opcode byte plus the longest immediate (10 LEB bytes).
   localparam int WIN_BYTES   = 11;
   localparam int FETCH_EXTRA = WIN_BYTES - 1;

   function automatic imm_kind_e classify_opcode(input logic [7:0] op);
      imm_kind_e k;
      case (op)
         OP_I32_CONST:  k = IMM_I32;
         OP_I64_CONST:  k = IMM_I64;
         OP_BR, OP_BR_IF, OP_CALL, OP_LOCAL_GET, OP_LOCAL_SET,
         OP_LOCAL_TEE, OP_GLOBAL_GET, OP_GLOBAL_SET: k = IMM_U32;
         default:       k = IMM_NONE;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] leb_max_bytes(input imm_kind_e k);
      logic [3:0] m;
      case (k)
         IMM_I64:  m = 4'd10;
         IMM_NONE: m = 4'd0;
         default:  m = 4'd5;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/insn_fetch_leb128_step.sv
// One LEB128 byte step: accumulate 7 payload bits at shift 7*idx, detect the
// final byte, sign/zero-extend on it and flag a continuation on the last legal byte.
module leb128_step
   import insn_fetch_pkg::*;
(
   input  logic [63:0] acc_in,
   input  logic [7:0]  byte_in,
   input  logic [3:0]  idx,
   input  imm_kind_e   kind,
   output logic [63:0] acc_out,
   output logic        last,
   output logic        overlong
);

   logic [6:0]  shamt;
   logic [6:0]  top_bit;
   logic [63:0] sum;
   logic [63:0] ext;

   always_comb begin
      shamt    = 7'(idx) * 7'd7;
      top_bit  = shamt + 7'd6;
      sum      = acc_in | ({57'b0, byte_in[6:0]} << shamt);
      last     = ~byte_in[7];
      overlong = byte_in[7] && (idx == leb_max_bytes(kind) - 4'd1);
      ext      = sum;
      // Bits above top_bit are still zero, so OR-ing ones in performs the extension.
      if (last && (kind != IMM_U32) && (top_bit < 7'd63) && sum[top_bit[5:0]]) begin
         ext = sum | (64'hFFFF_FFFF_FFFF_FFFF << (top_bit + 7'd1));
      end
      case (kind)
         IMM_I32: acc_out = last ? {{32{ext[31]}}, ext[31:0]} : ext;
         IMM_U32: acc_out = last ? {32'b0, ext[31:0]} : ext;
         default: acc_out = ext;
      endcase
   end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch/decode front end: reads an 11-byte ROM window at pc, decodes
// the opcode and its LEB128 immediate one byte per cycle, and hands off via valid/ready.
module insn_fetch
   import insn_fetch_pkg::*;
#(
   parameter int MEM_DEPTH = 4,
   parameter int MEM_EXTRA = 4
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [MEM_DEPTH:0]            pc,
   output logic                          busy,
   output logic [MEM_DEPTH:0]            mem_addr,
   output logic [MEM_EXTRA-1:0]          mem_extra,
   input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
   input  logic                          mem_error,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    opcode,
   output logic [63:0]                   imm,
   output logic [MEM_DEPTH:0]            next_pc,
   output logic [3:0]                    trap
);

   localparam int AW = MEM_DEPTH + 1;
   localparam int DW = (2**MEM_EXTRA) * 8;

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [7:0]      win_q [WIN_BYTES];
   logic [7:0]      win_d [WIN_BYTES];
   logic [7:0]      opcode_q, opcode_d;
   logic [63:0]     imm_q, imm_d;
   logic [AW-1:0]   next_pc_q, next_pc_d;
   logic [3:0]      trap_q, trap_d;
   logic [3:0]      leb_idx_q, leb_idx_d;
   imm_kind_e       kind_q, kind_d;

   logic [7:0]      leb_byte;
   logic [63:0]     step_acc;
   logic            step_last;
   logic            step_overlong;
   logic            fetching;
   logic            unused_hi;

   assign unused_hi = ^mem_data[DW-1:8*WIN_BYTES];

   // Window byte 0 is the opcode; LEB byte i sits at window byte i+1.
   assign leb_byte = win_q[4'(leb_idx_q + 4'd1)];

   leb128_step u_leb (
      .acc_in   (imm_q),
      .byte_in  (leb_byte),
      .idx      (leb_idx_q),
      .kind     (kind_q),
      .acc_out  (step_acc),
      .last     (step_last),
      .overlong (step_overlong)
   );

   // The opcode is classified straight off mem_data at the WAIT edge so that a
   // no-immediate instruction is valid after edge 2; OPC consumes the first LEB byte.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      win_d     = win_q;
      opcode_d  = opcode_q;
      imm_d     = imm_q;
      next_pc_d = next_pc_q;
      trap_d    = trap_q;
      leb_idx_d = leb_idx_q;
      kind_d    = kind_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = pc;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_WAIT;
         ST_WAIT: begin
            for (int k = 0; k < WIN_BYTES; k++) begin
               win_d[k] = mem_data[8*k +: 8];
            end
            opcode_d  = mem_data[7:0];
            imm_d     = '0;
            leb_idx_d = '0;
            kind_d    = classify_opcode(mem_data[7:0]);
            if (mem_error) begin
               trap_d  = TRAP_MEM;
               state_d = ST_TRAP;
            end else if (kind_d == IMM_NONE) begin
               next_pc_d = pc_q + AW'(1);
               state_d   = ST_DONE;
            end else begin
               state_d = ST_OPC;
            end
         end
         ST_OPC, ST_LEB: begin
            imm_d     = step_acc;
            leb_idx_d = leb_idx_q + 4'd1;
            if (step_overlong) begin
               trap_d  = TRAP_LEB_OVERLONG;
               state_d = ST_TRAP;
            end else if (step_last) begin
               next_pc_d = pc_q + AW'(leb_idx_q) + AW'(2);
               state_d   = ST_DONE;
            end else begin
               state_d = ST_LEB;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         for (int k = 0; k < WIN_BYTES; k++) win_q[k] <= '0;
         opcode_q  <= '0;
         imm_q     <= '0;
         next_pc_q <= '0;
         trap_q    <= TRAP_NONE;
         leb_idx_q <= '0;
         kind_q    <= IMM_NONE;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         for (int k = 0; k < WIN_BYTES; k++) win_q[k] <= win_d[k];
         opcode_q  <= opcode_d;
         imm_q     <= imm_d;
         next_pc_q <= next_pc_d;
         trap_q    <= trap_d;
         leb_idx_q <= leb_idx_d;
         kind_q    <= kind_d;
      end
   end

   assign fetching  = (state_q == ST_FETCH) || (state_q == ST_WAIT);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign mem_addr  = fetching ? pc_q : '0;
   assign mem_extra = fetching ? MEM_EXTRA'(FETCH_EXTRA) : '0;
   assign opcode    = opcode_q;
   assign imm       = imm_q;
   assign next_pc   = next_pc_q;
   assign trap      = trap_q;

endmodule
